seq_divider_8bit: RTL and testbench

//   Multi-cycle restoring divider for the 8-bit ALU: quotient and remainder of dividend/divisor.

---
 rtl/seq_divider_8bit.sv | 142 ++++++++++++++
 tb/tb_seq_divider_8bit.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider_8bit.sv
// Multi-cycle restoring divider: one trial subtract (A + ~B + 1) per clock, start/done handshake.
// Define SEQ_DIV_SIGNED_EN to add the signed_op port and two's-complement division.
module seq_divider_8bit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef SEQ_DIV_SIGNED_EN
  input  logic             signed_op,
`endif
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned     CntW     = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastStep = CntW'(WIDTH - 1);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);
  localparam logic [WIDTH-1:0] One     = WIDTH'(1);

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] dvd_q;   // dividend bits leave at the MSB, quotient bits enter at the LSB
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] rem_q;
  logic             q_neg_q;
  logic             r_neg_q;

  logic             sop;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   low_diff;
  logic             no_borrow;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH-1:0] quo_final;
  logic [WIDTH-1:0] rem_final;

`ifdef SEQ_DIV_SIGNED_EN
  assign sop = signed_op;
`else
  assign sop = 1'b0;
`endif

  // Operand conditioning at capture: signed operands are reduced to magnitudes.
  always_comb begin
    a_neg = sop & dividend[WIDTH-1];
    b_neg = sop & divisor[WIDTH-1];
    a_mag = a_neg ? (~dividend + One) : dividend;
    b_mag = b_neg ? (~divisor + One) : divisor;
  end

  // One restoring step. The shifted value carries WIDTH+1 bits; if its top bit is set it
  // already exceeds the divisor, otherwise the carry out of the low WIDTH-bit subtract decides.
  always_comb begin
    shifted   = {rem_q, dvd_q[WIDTH-1]};
    low_diff  = {1'b0, shifted[WIDTH-1:0]} + {1'b0, ~dvs_q} + {1'b0, One};
    no_borrow = shifted[WIDTH] | low_diff[WIDTH];
    rem_next  = no_borrow ? low_diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_next  = {dvd_q[WIDTH-2:0], no_borrow};
    quo_final = q_neg_q ? (~quo_next + One) : quo_next;
    rem_final = r_neg_q ? (~rem_next + One) : rem_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            if (divisor == '0) begin
              // Resolved on the accepting edge; busy never rises.
              state_q     <= StDone;
              busy        <= 1'b0;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state_q <= StCalc;
              busy    <= 1'b1;
              cnt_q   <= '0;
              dvd_q   <= a_mag;
              dvs_q   <= b_mag;
              rem_q   <= '0;
              q_neg_q <= a_neg ^ b_neg;
              r_neg_q <= a_neg;
            end
          end else begin
            state_q <= StIdle;
          end
        end
        StCalc: begin
          dvd_q <= quo_next;
          rem_q <= rem_next;
          cnt_q <= cnt_q + CntOne;
          if (cnt_q == LastStep) begin
            state_q     <= StDone;
            busy        <= 1'b0;
            done        <= 1'b1;
            quotient    <= quo_final;
            remainder   <= rem_final;
            div_by_zero <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider_8bit.sv
// Bench for seq_divider_8bit: directed and random divisions scored against a queue of
// expected results computed with plain integer arithmetic.
module tb_seq_divider_8bit;
  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
`ifdef SEQ_DIV_SIGNED_EN
  logic         signed_op;
`endif
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  seq_divider_8bit #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
`ifdef SEQ_DIV_SIGNED_EN
    .signed_op  (signed_op),
`endif
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    logic         sop;
    int           due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc   = 0;
  int   n_vec = 0;
  int   n_err = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sop, input int due);
    exp_t e;
    int   sa, sbv, qi, ri;
    e.a   = a;
    e.b   = b;
    e.sop = sop;
    e.due = due;
    e.dbz = 1'b0;
    if (b == 0) begin
      e.q   = '1;
      e.r   = a;
      e.dbz = 1'b1;
    end else if (sop) begin
      sa  = int'($signed(a));
      sbv = int'($signed(b));
      qi  = sa / sbv;
      ri  = sa % sbv;
      e.q = qi[W-1:0];
      e.r = ri[W-1:0];
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pops one expected result.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL spurious_done: done=1 at cycle %0d, expected done=0", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("quotient", 64'(quotient), 64'(mon_e.q));
        check("remainder", 64'(remainder), 64'(mon_e.r));
        check("div_by_zero", 64'(div_by_zero), 64'(mon_e.dbz));
        check("latency_cycle", 64'(cyc), 64'(mon_e.due));
        if (!mon_e.dbz && !mon_e.sop) begin
          check("invariant_eq", 64'(int'(quotient) * int'(mon_e.b) + int'(remainder)),
                64'(int'(mon_e.a)));
          check("invariant_lt", 64'(remainder < mon_e.b), 64'(1));
        end
      end
    end
  end

  // Call at a negedge; returns 1 time unit after the accepting edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sop);
    logic s;
    s = sop;
`ifdef SEQ_DIV_SIGNED_EN
    signed_op = s;
`else
    s = 1'b0;
`endif
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    sb.push_back(model(a, b, s, cyc + 1 + ((b == 0) ? 0 : W)));
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic drain(input int budget);
    int i;
    i = 0;
    while (sb.size() != 0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  // Returns at the negedge on which done is high.
  task automatic wait_done(input int budget);
    int i;
    i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (!done && i < budget);
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_done_timeout: done=0 after %0d cycles, expected done=1", budget);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_done"}, 64'(done), 64'(0));
    check({tag, "_quotient"}, 64'(quotient), 64'(0));
    check({tag, "_remainder"}, 64'(remainder), 64'(0));
    check({tag, "_div_by_zero"}, 64'(div_by_zero), 64'(0));
  endtask

  logic [W-1:0] bnd_a[4] = '{8'd255, 8'd5, 8'd0, 8'd255};
  logic [W-1:0] bnd_b[4] = '{8'd1, 8'd9, 8'd3, 8'd255};

  initial begin
    int           nb;
    int           sel;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    rst_n    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
`ifdef SEQ_DIV_SIGNED_EN
    signed_op = 1'b0;
`endif
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // 200/7 with busy-width measurement
    issue(8'd200, 8'd7, 1'b0);
    nb = 0;
    repeat (W + 2) begin
      @(negedge clk);
      if (busy) nb++;
    end
    check("busy_cycles", 64'(nb), 64'(W));
    drain(20);

    foreach (bnd_a[i]) begin
      issue(bnd_a[i], bnd_b[i], 1'b0);
      drain(20);
    end

    // divide by zero, then a normal result clears the flag
    issue(8'h55, 8'd0, 1'b0);
    drain(20);
    issue(8'd10, 8'd3, 1'b0);
    drain(20);

    // start during CALC is ignored; start in the DONE cycle is taken back-to-back
    issue(8'd100, 8'd9, 1'b0);
    @(negedge clk);
    @(negedge clk);
    dividend = 8'd50;
    divisor  = 8'd5;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(20);
    issue(8'd50, 8'd5, 1'b0);
    wait_done(20);
    issue(8'h33, 8'd0, 1'b0);
    wait_done(4);
    issue(8'd9, 8'd4, 1'b0);
    drain(20);

    // reset in mid-division aborts it
    issue(8'd200, 8'd7, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("abort");
    sb.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (W + 4) @(negedge clk);
    issue(8'd9, 8'd2, 1'b0);
    drain(20);

`ifdef SEQ_DIV_SIGNED_EN
    issue(8'h9C, 8'd7, 1'b1);
    drain(20);
    issue(8'd100, 8'hF9, 1'b1);
    drain(20);
    issue(8'h80, 8'hFF, 1'b1);
    drain(20);
    issue(8'h80, 8'd0, 1'b1);
    drain(20);
`endif

    for (int i = 0; i < 1000; i++) begin
      sel = int'($urandom_range(0, 7));
      ra  = W'($urandom);
      if (sel == 0) rb = '0;
      else if (sel < 4) rb = W'($urandom_range(1, 15));
      else rb = W'($urandom);
      issue(ra, rb, 1'b0);
      if ($urandom_range(0, 3) == 0) wait_done(W + 4);
      else drain(W + 8);
    end
    drain(W + 8);

`ifdef SEQ_DIV_SIGNED_EN
    for (int i = 0; i < 300; i++) begin
      ra = W'($urandom);
      rb = ($urandom_range(0, 9) == 0) ? W'(0) : W'($urandom);
      issue(ra, rb, 1'($urandom_range(0, 1)));
      drain(W + 8);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
